// File: rtl/comporta_agendador_pkg.sv
// Shared definitions for the gate scheduler.
// Holds the 4-bit state encodings shown on dbEstado, the default rest and
// ack-timeout intervals, and a small helper used to size counters.
package comporta_agendador_pkg;

  localparam logic [3:0] EST_INICIAL  = 4'd0;
  localparam logic [3:0] EST_ESPERA   = 4'd1;
  localparam logic [3:0] EST_PEDE     = 4'd2;
  localparam logic [3:0] EST_EXECUTA  = 4'd3;
  localparam logic [3:0] EST_DESCANSO = 4'd4;
  localparam logic [3:0] EST_ERRO     = 4'd15;

  // 1 s at 50 MHz
  localparam int unsigned DESCANSO_PADRAO    = 50_000_000;
  localparam int unsigned TIMEOUT_ACK_PADRAO = 1000;

  function automatic int unsigned maxUint(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/contador_pendentes.sv
// Saturating pending-request counter for the gate scheduler.
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-high reset
//   pedidoSerial      one-clock request pulse
//   pedidoIntervalo   request level; each rising edge is one request
//   dec               dispatch of one queued request this cycle
//   limpar            clears the queue, the in-flight requests and the flag
//   pendentes         queued requests, saturating at MAX_PENDENTES
//   erroOverflow      sticky, set when a request was lost at saturation
module contador_pendentes #(
  parameter int unsigned MAX_PENDENTES = 7,
  parameter int unsigned LARGURA       = $clog2(MAX_PENDENTES + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               pedidoSerial,
  input  logic               pedidoIntervalo,
  input  logic               dec,
  input  logic               limpar,
  output logic [LARGURA-1:0] pendentes,
  output logic               erroOverflow
);

  localparam logic [LARGURA+1:0] MAX_V = MAX_PENDENTES[LARGURA+1:0];

  logic               intervaloAnt;
  logic [1:0]         incReg;
  logic [1:0]         incNovo;
  logic [LARGURA+1:0] soma;

  // Requests are captured one cycle before they are added, so a pulse at
  // edge n is visible on pendentes after edge n+1.
  always_comb begin
    incNovo = {1'b0, pedidoSerial} + {1'b0, pedidoIntervalo & ~intervaloAnt};
    soma    = {2'b00, pendentes} + {{LARGURA{1'b0}}, incReg}
              - {{(LARGURA + 1){1'b0}}, dec};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      intervaloAnt <= 1'b0;
      incReg       <= '0;
      pendentes    <= '0;
      erroOverflow <= 1'b0;
    end else begin
      intervaloAnt <= pedidoIntervalo;
      if (limpar) begin
        // Requests already captured are dropped along with the queue.
        incReg       <= '0;
        pendentes    <= '0;
        erroOverflow <= 1'b0;
      end else begin
        incReg <= incNovo;
        if (soma > MAX_V) begin
          pendentes    <= MAX_V[LARGURA-1:0];
          erroOverflow <= 1'b1;
        end else begin
          pendentes <= soma[LARGURA-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/comporta_agendador.sv
// Gate scheduler: queues gate-open requests from the serial path and the
// interval detector and dispatches them one at a time to the gate
// controller over a req/ack handshake, with a rest interval after each
// gate cycle, an ack timeout and a queue-overflow flag.
// Ports:
//   clock, reset       rising-edge clock, asynchronous active-high reset
//   pedidoSerial       one-clock request pulse
//   pedidoIntervalo    request level, one request per rising edge
//   cancelar           clears queue and error flags, aborts PEDE/ERRO
//   comportaOcupada    ack, high while a gate cycle runs
//   fimCiclo           gate back at closed position
//   abrirComporta      request to gate controller, high only in PEDE
//   pendentes          queued requests not yet dispatched
//   erroTimeout        sticky ack-timeout flag
//   erroOverflow       sticky queue-overflow flag
//   dbEstado           current state encoding
module comporta_agendador
  import comporta_agendador_pkg::*;
#(
  parameter int unsigned MAX_PENDENTES = 7,
  parameter int unsigned DESCANSO      = DESCANSO_PADRAO,
  parameter int unsigned TIMEOUT_ACK   = TIMEOUT_ACK_PADRAO
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               pedidoSerial,
  input  logic                               pedidoIntervalo,
  input  logic                               cancelar,
  input  logic                               comportaOcupada,
  input  logic                               fimCiclo,
  output logic                               abrirComporta,
  output logic [$clog2(MAX_PENDENTES+1)-1:0] pendentes,
  output logic                               erroTimeout,
  output logic                               erroOverflow,
  output logic [3:0]                         dbEstado
);

  localparam int unsigned LARG_PEND = $clog2(MAX_PENDENTES + 1);
  localparam int unsigned LARG_CONT = $clog2(maxUint(DESCANSO, TIMEOUT_ACK) + 1);
  localparam logic [LARG_CONT-1:0] FIM_DESCANSO = LARG_CONT'(DESCANSO - 1);
  localparam logic [LARG_CONT-1:0] FIM_TIMEOUT  = LARG_CONT'(TIMEOUT_ACK - 1);
  localparam logic [LARG_CONT-1:0] UM           = LARG_CONT'(1);

  logic [3:0]           estado;
  logic [LARG_CONT-1:0] contador;
  logic                 despacha;

  // A cancel empties the queue this cycle, so it also suppresses dispatch.
  always_comb begin
    despacha = !cancelar && (pendentes != '0) &&
               ((estado == EST_ESPERA) ||
                ((estado == EST_DESCANSO) && (contador == FIM_DESCANSO)));
  end

  contador_pendentes #(
    .MAX_PENDENTES(MAX_PENDENTES),
    .LARGURA      (LARG_PEND)
  ) uPendentes (
    .clock          (clock),
    .reset          (reset),
    .pedidoSerial   (pedidoSerial),
    .pedidoIntervalo(pedidoIntervalo),
    .dec            (despacha),
    .limpar         (cancelar),
    .pendentes      (pendentes),
    .erroOverflow   (erroOverflow)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado      <= EST_INICIAL;
      contador    <= '0;
      erroTimeout <= 1'b0;
    end else begin
      if (cancelar) erroTimeout <= 1'b0;
      case (estado)
        EST_INICIAL: estado <= EST_ESPERA;
        EST_ESPERA: begin
          if (despacha) begin
            estado   <= EST_PEDE;
            contador <= '0;
          end
        end
        EST_PEDE: begin
          if (cancelar) begin
            estado <= EST_ESPERA;
          end else if (comportaOcupada) begin
            estado <= EST_EXECUTA;
          end else if (contador == FIM_TIMEOUT) begin
            estado      <= EST_ERRO;
            erroTimeout <= 1'b1;
          end else begin
            contador <= contador + UM;
          end
        end
        EST_EXECUTA: begin
          if (fimCiclo) begin
            estado   <= EST_DESCANSO;
            contador <= '0;
          end
        end
        EST_DESCANSO: begin
          if (contador == FIM_DESCANSO) begin
            estado   <= despacha ? EST_PEDE : EST_ESPERA;
            contador <= '0;
          end else begin
            contador <= contador + UM;
          end
        end
        EST_ERRO: if (cancelar) estado <= EST_ESPERA;
        default:  estado <= EST_INICIAL;
      endcase
    end
  end

  // Decoded from the state register so it drops as soon as reset asserts.
  assign abrirComporta = (estado == EST_PEDE);
  assign dbEstado      = estado;

endmodule

// File: tb/tb_comporta_agendador.sv
module tb_comporta_agendador;

  localparam int DESC = 20;
  localparam int TOUT = 8;
  localparam int MAXP = 7;

  localparam int S_INICIAL  = 0;
  localparam int S_ESPERA   = 1;
  localparam int S_PEDE     = 2;
  localparam int S_EXECUTA  = 3;
  localparam int S_DESCANSO = 4;
  localparam int S_ERRO     = 15;

  logic       clock = 1'b0;
  logic       reset;
  logic       pedidoSerial, pedidoIntervalo, cancelar, comportaOcupada, fimCiclo;
  logic       abrirComporta, erroTimeout, erroOverflow;
  logic [2:0] pendentes;
  logic [3:0] dbEstado;

  always #5 clock = ~clock;

  comporta_agendador #(
    .MAX_PENDENTES(MAXP),
    .DESCANSO     (DESC),
    .TIMEOUT_ACK  (TOUT)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .pedidoSerial   (pedidoSerial),
    .pedidoIntervalo(pedidoIntervalo),
    .cancelar       (cancelar),
    .comportaOcupada(comportaOcupada),
    .fimCiclo       (fimCiclo),
    .abrirComporta  (abrirComporta),
    .pendentes      (pendentes),
    .erroTimeout    (erroTimeout),
    .erroOverflow   (erroOverflow),
    .dbEstado       (dbEstado)
  );

  int checks = 0;
  int failures = 0;

  task automatic verifica(input string tag, input logic [31:0] obtido, input logic [31:0] esperado);
    checks++;
    if (obtido !== esperado) begin
      failures++;
      $display("FAIL %s: obtido=%0d esperado=%0d (t=%0t)", tag, obtido, esperado, $time);
    end
  endtask

  // Reference model: phase, queue length, requests captured but not yet
  // queued, time spent in the current phase, sticky flags.
  int mEst, mPend, mTransito, mTempo, mErrT, mErrO, mPrevInt;

  task automatic modeloReset();
    mEst = S_INICIAL; mPend = 0; mTransito = 0; mTempo = 0;
    mErrT = 0; mErrO = 0; mPrevInt = 0;
  endtask

  task automatic modeloPasso(input int s, input int i, input int c, input int o, input int f);
    int prox;
    int saiu;
    int temFila;
    int novos;
    int t;
    prox    = mEst;
    saiu    = 0;
    temFila = (mPend > 0 && c == 0) ? 1 : 0;
    novos   = s + ((i != 0 && mPrevInt == 0) ? 1 : 0);
    case (mEst)
      S_INICIAL: prox = S_ESPERA;
      S_ESPERA: if (temFila != 0) begin prox = S_PEDE; saiu = 1; end
      S_PEDE: begin
        if (c != 0) prox = S_ESPERA;
        else if (o != 0) prox = S_EXECUTA;
        else if (mTempo + 1 == TOUT) begin prox = S_ERRO; mErrT = 1; end
      end
      S_EXECUTA: if (f != 0) prox = S_DESCANSO;
      S_DESCANSO: begin
        if (mTempo + 1 == DESC) begin
          if (temFila != 0) begin prox = S_PEDE; saiu = 1; end
          else prox = S_ESPERA;
        end
      end
      S_ERRO: if (c != 0) prox = S_ESPERA;
      default: prox = S_INICIAL;
    endcase
    if (c != 0) begin
      mErrT = 0; mErrO = 0; mPend = 0; mTransito = 0;
    end else begin
      t = mPend + mTransito - saiu;
      if (t > MAXP) begin t = MAXP; mErrO = 1; end
      mPend = t;
      mTransito = novos;
    end
    mPrevInt = i;
    mTempo = (prox == mEst) ? mTempo + 1 : 0;
    mEst = prox;
  endtask

  task automatic confere();
    verifica("estado", dbEstado, mEst);
    verifica("pendentes", pendentes, mPend);
    verifica("abrirComporta", abrirComporta, (mEst == S_PEDE) ? 1 : 0);
    verifica("erroTimeout", erroTimeout, mErrT);
    verifica("erroOverflow", erroOverflow, mErrO);
  endtask

  // Called at a falling edge: drive inputs, take one clock, check outputs.
  task automatic passo(input bit s, input bit i, input bit c, input bit o, input bit f);
    pedidoSerial = s; pedidoIntervalo = i; cancelar = c;
    comportaOcupada = o; fimCiclo = f;
    @(posedge clock);
    modeloPasso(int'(s), int'(i), int'(c), int'(o), int'(f));
    @(negedge clock);
    confere();
  endtask

  task automatic aplicaReset();
    pedidoSerial = 0; pedidoIntervalo = 0; cancelar = 0;
    comportaOcupada = 0; fimCiclo = 0;
    reset = 1'b1;
    #1;
    verifica("rst_async_estado", dbEstado, 0);
    verifica("rst_async_abrir", abrirComporta, 0);
    verifica("rst_async_pend", pendentes, 0);
    verifica("rst_async_errT", erroTimeout, 0);
    verifica("rst_async_errO", erroOverflow, 0);
    modeloReset();
    @(posedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
  endtask

  // Well-behaved gate controller: acks at once, finishes after 4 cycles.
  task automatic rodaControlador(input int ciclos, output int entradasPede);
    int tExec;
    int anterior;
    tExec = 0;
    anterior = int'(dbEstado);
    entradasPede = 0;
    for (int k = 0; k < ciclos; k++) begin
      passo(0, 0, 0, (mEst == S_PEDE) || (mEst == S_EXECUTA && tExec < 3),
            (mEst == S_EXECUTA) && (tExec == 3));
      tExec = (mEst == S_EXECUTA) ? tExec + 1 : 0;
      if (int'(dbEstado) == S_PEDE && anterior != S_PEDE) entradasPede++;
      anterior = int'(dbEstado);
    end
  endtask

  initial begin
    int n;
    bit nivel;
    reset = 1'b1;
    pedidoSerial = 0; pedidoIntervalo = 0; cancelar = 0;
    comportaOcupada = 0; fimCiclo = 0;
    modeloReset();
    repeat (2) @(negedge clock);
    verifica("reset_estado", dbEstado, S_INICIAL);
    verifica("reset_abrir", abrirComporta, 0);
    verifica("reset_pend", pendentes, 0);
    verifica("reset_errT", erroTimeout, 0);
    verifica("reset_errO", erroOverflow, 0);
    reset = 1'b0;
    passo(0, 0, 0, 0, 0);
    verifica("inicial_para_espera", dbEstado, S_ESPERA);

    // Single request: latency, ack, 20-cycle rest, back to idle.
    passo(1, 0, 0, 0, 0);
    verifica("lat_n_pend", pendentes, 0);
    verifica("lat_n_abrir", abrirComporta, 0);
    passo(0, 0, 0, 0, 0);
    verifica("lat_n1_pend", pendentes, 1);
    verifica("lat_n1_abrir", abrirComporta, 0);
    passo(0, 0, 0, 0, 0);
    verifica("lat_n2_abrir", abrirComporta, 1);
    verifica("lat_n2_pend", pendentes, 0);
    passo(0, 0, 0, 1, 0);
    verifica("ack_executa", dbEstado, S_EXECUTA);
    verifica("executa_abrir", abrirComporta, 0);
    repeat (9) passo(0, 0, 0, 1, 0);
    passo(0, 0, 0, 1, 1);
    verifica("descanso_dur", dbEstado, S_DESCANSO);
    repeat (19) begin
      passo(0, 0, 0, 0, 0);
      verifica("descanso_dur", dbEstado, S_DESCANSO);
    end
    passo(0, 0, 0, 0, 0);
    verifica("descanso_fim_espera", dbEstado, S_ESPERA);
    verifica("descanso_fim_pend", pendentes, 0);

    // Queueing: 3 requests during EXECUTA, rest ends straight in PEDE.
    passo(1, 0, 0, 0, 0); passo(0, 0, 0, 0, 0); passo(0, 0, 0, 0, 0);
    passo(0, 0, 0, 1, 0);
    repeat (3) passo(1, 0, 0, 1, 0);
    repeat (2) passo(0, 0, 0, 1, 0);
    verifica("fila_tres", pendentes, 3);
    passo(0, 0, 0, 1, 1);
    repeat (19) passo(0, 0, 0, 0, 0);
    passo(0, 0, 0, 0, 0);
    verifica("fila_direto_pede", dbEstado, S_PEDE);
    verifica("fila_direto_pend", pendentes, 2);
    rodaControlador(120, n);
    verifica("fila_ciclos_extra", n, 2);
    verifica("fila_fim_espera", dbEstado, S_ESPERA);

    // Simultaneous sources, held level, overflow and cancel in EXECUTA.
    passo(1, 0, 0, 0, 0); passo(0, 0, 0, 0, 0); passo(0, 0, 0, 0, 0);
    passo(0, 0, 0, 1, 0);
    passo(1, 1, 0, 1, 0);
    repeat (2) passo(0, 1, 0, 1, 0);
    verifica("simultaneo_dois", pendentes, 2);
    repeat (50) passo(0, 1, 0, 1, 0);
    verifica("intervalo_nivel", pendentes, 2);
    passo(0, 0, 0, 1, 0);
    passo(0, 0, 1, 1, 0);
    verifica("cancela_zera", pendentes, 0);
    repeat (9) passo(1, 0, 0, 1, 0);
    repeat (2) passo(0, 0, 0, 1, 0);
    verifica("overflow_satura", pendentes, MAXP);
    verifica("overflow_flag", erroOverflow, 1);
    passo(0, 0, 1, 1, 0);
    verifica("cancela_pend", pendentes, 0);
    verifica("cancela_errO", erroOverflow, 0);
    verifica("cancela_fica_executa", dbEstado, S_EXECUTA);
    passo(0, 0, 0, 1, 1);
    repeat (20) passo(0, 0, 0, 0, 0);
    verifica("pos_overflow_espera", dbEstado, S_ESPERA);

    // Ack timeout.
    passo(1, 0, 0, 0, 0); passo(0, 0, 0, 0, 0); passo(0, 0, 0, 0, 0);
    verifica("timeout_pede", abrirComporta, 1);
    repeat (7) begin
      passo(0, 0, 0, 0, 0);
      verifica("timeout_ainda_pede", dbEstado, S_PEDE);
    end
    passo(0, 0, 0, 0, 0);
    verifica("timeout_erro", dbEstado, S_ERRO);
    verifica("timeout_flag", erroTimeout, 1);
    verifica("timeout_abrir", abrirComporta, 0);
    repeat (3) passo(0, 0, 0, 0, 0);
    verifica("erro_segura", dbEstado, S_ERRO);
    passo(0, 0, 1, 0, 0);
    verifica("erro_cancela", dbEstado, S_ESPERA);
    verifica("erro_cancela_flag", erroTimeout, 0);

    // Reset in the middle of a rest with 2 queued.
    passo(1, 0, 0, 0, 0); passo(0, 0, 0, 0, 0); passo(0, 0, 0, 0, 0);
    passo(0, 0, 0, 1, 0);
    repeat (2) passo(1, 0, 0, 1, 0);
    repeat (2) passo(0, 0, 0, 1, 0);
    passo(0, 0, 0, 1, 1);
    repeat (5) passo(0, 0, 0, 0, 0);
    verifica("pre_reset_estado", dbEstado, S_DESCANSO);
    verifica("pre_reset_pend", pendentes, 2);
    aplicaReset();
    verifica("pos_reset_inicial", dbEstado, S_INICIAL);
    passo(0, 0, 0, 0, 0);
    verifica("pos_reset_espera", dbEstado, S_ESPERA);
    repeat (5) passo(0, 0, 0, 0, 0);
    verifica("pos_reset_sem_pedido", abrirComporta, 0);
    verifica("pos_reset_pend", pendentes, 0);

    // Randomized traffic, including misbehaving controller and resets.
    nivel = 0;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 299) == 0) begin
        aplicaReset();
        nivel = 0;
      end else begin
        if ($urandom_range(0, 5) == 0) nivel = !nivel;
        passo($urandom_range(0, 7) == 0, nivel, $urandom_range(0, 149) == 0,
              (mEst == S_PEDE)    ? ($urandom_range(0, 3) == 0) :
              (mEst == S_EXECUTA) ? ($urandom_range(0, 4) != 0) :
                                    ($urandom_range(0, 19) == 0),
              (mEst == S_EXECUTA) ? ($urandom_range(0, 5) == 0) :
                                    ($urandom_range(0, 39) == 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/comporta_agendador.md
Name: comporta_agendador

Overview:
Scheduler that sits between the gate request sources and the gate controller.
- Request sources: the serial command path and the weight-interval detector.
- Gate controller: the servo/PWM sequencer.
- Requests are queued in a saturating pending-request counter and dispatched one at a time over a req/ack handshake.
- After each completed cycle the block enforces a minimum rest interval, and it flags handshake timeouts and queue overflow.

Parameters:
MAX_PENDENTES, 7, saturation value of the pending counter; counter width = $clog2(MAX_PENDENTES+1).
DESCANSO, 50000000, rest interval in clocks after each gate cycle (1 s at 50 MHz).
TIMEOUT_ACK, 1000, clocks allowed in PEDE before comportaOcupada must rise.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
pedidoSerial  in  1  one-clock pulse, one gate-open request from the serial command path
pedidoIntervalo  in  1  level from the interval detector; each rising edge is one request
cancelar  in  1  one-clock pulse; clears queue and error flags
comportaOcupada  in  1  ack from gate controller, high while a gate cycle runs
fimCiclo  in  1  one-clock pulse from gate controller, gate back at closed position
abrirComporta  out  1  request to gate controller (Moore output, high only in PEDE)
pendentes  out  $clog2(MAX_PENDENTES+1)  queued requests not yet dispatched
erroTimeout  out  1  sticky, ack not received within TIMEOUT_ACK
erroOverflow  out  1  sticky, a request was lost at saturation
dbEstado  out  4  current state encoding, for debug display

Behaviour:
- Reset values: async reset forces state INICIAL, every counter to 0, abrirComporta=0, pendentes=0, erroTimeout=0, erroOverflow=0, dbEstado=0. The edge-detector register is also cleared.
- Request counting:
  - inc = pedidoSerial + rise(pedidoIntervalo), giving 0..2.
  - dec = 1 on the cycle the FSM moves ESPERA->PEDE or DESCANSO->PEDE.
  - next = min(pendentes + inc - dec, MAX_PENDENTES).
  - If the unsaturated sum exceeds MAX_PENDENTES, erroOverflow is set to 1.
  - A simultaneous pulse on both sources counts as 2.
  - A dispatch decrement on the same cycle as an increment is netted before saturation.
- pedidoIntervalo held high is one request only. A new request needs low then high again.
- State encodings: INICIAL=0, ESPERA=1, PEDE=2, EXECUTA=3, DESCANSO=4, ERRO=15.
- State transitions:
  - INICIAL -> ESPERA unconditionally after reset.
  - ESPERA -> PEDE when pendentes>0 (decrements the counter).
  - PEDE: abrirComporta=1 and the timeout counter runs.
    - comportaOcupada=1 -> EXECUTA.
    - Timeout counter reaches TIMEOUT_ACK-1 -> ERRO, sets erroTimeout.
  - EXECUTA: abrirComporta=0; waits for fimCiclo=1 -> DESCANSO, rest counter cleared.
  - DESCANSO: rest counter counts to DESCANSO-1.
    - At terminal count with pendentes>0 -> PEDE (decrement).
    - At terminal count with pendentes=0 -> ESPERA.
  - ERRO: holds; cancelar -> ESPERA.
- Latency: a request pulse sampled at edge n updates pendentes at n+1, enters PEDE at n+2, and abrirComporta is high after edge n+2.
- cancelar:
  - Always: pendentes=0 next cycle, erroOverflow=0, erroTimeout=0.
  - In PEDE or ERRO: go to ESPERA.
  - In EXECUTA or DESCANSO: no state change, because the mechanical cycle must complete.
  - cancelar wins over a same-cycle increment.
- fimCiclo outside EXECUTA is ignored. comportaOcupada dropping without fimCiclo keeps the FSM in EXECUTA.
- Reset mid-operation returns to INICIAL immediately. abrirComporta falls asynchronously.

Decomposition:
- Shared package holds the state encodings (4-bit localparams) and the default DESCANSO/TIMEOUT_ACK constants.
- One sub-module, contador_pendentes: a saturating up/down counter with inc(0..2), dec, clear and overflow flag, plus the rising-edge detector for pedidoIntervalo.
- The FSM and the timeout/rest counters stay in comporta_agendador.

Test Plan (DESCANSO=20, TIMEOUT_ACK=8 for sim):
- Single request: pedidoSerial pulse, ack 1 cycle after abrirComporta, fimCiclo 10 cycles later -> abrirComporta high 2 edges after the pulse; DESCANSO lasts 20 cycles; ends in ESPERA with pendentes=0.
- Queueing: 3 pulses during EXECUTA -> pendentes=3. After the first rest, PEDE is re-entered directly with no ESPERA visit, and 3 further gate cycles follow.
- Simultaneous sources: pedidoSerial pulse plus pedidoIntervalo rising on the same edge -> pendentes increases by 2. pedidoIntervalo held high for 50 cycles -> one request only.
- Overflow: 9 requests while in EXECUTA -> pendentes=7, erroOverflow=1. A cancelar pulse -> pendentes=0, erroOverflow=0, state stays EXECUTA.
- Timeout: comportaOcupada stuck at 0 -> ERRO (dbEstado=15) after 8 cycles in PEDE, erroTimeout=1, abrirComporta=0. cancelar -> ESPERA.
- Async reset asserted mid-DESCANSO with pendentes=2 -> all outputs 0 immediately. After release: INICIAL then ESPERA, no request issued.
